// File: rtl/seg7_scan_driver.sv
// Time-multiplexed N-digit seven-segment driver with a double-buffered digit
// store, guard-banded digit scanning, leading-zero blanking and tear-free commit.
module seg7_scan_driver #(
  parameter int DIGITS       = 4,
  parameter int REFRESH_DIV  = 1024,
  parameter int GUARD        = 2,
  parameter int HEX_EN       = 1,
  parameter int COMMON_ANODE = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [2:0]        wr_addr,
  input  logic [3:0]        wr_data,
  input  logic              wr_dp,
  input  logic              commit,
  input  logic              lz_suppress,
  output logic              pending,
  output logic [6:0]        seg_out,
  output logic              dp_out,
  output logic [DIGITS-1:0] dig_sel,
  output logic              frame_tick
);

  localparam int SLOT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DIGITS - 1);
  localparam logic INV = (COMMON_ANODE != 0);

  logic [SLOT_W-1:0] slot_cnt;
  logic [IDX_W-1:0]  idx;
  logic [3:0]        shadow [DIGITS];
  logic [3:0]        active [DIGITS];
  logic [DIGITS-1:0] shadow_dp;
  logic [DIGITS-1:0] active_dp;
  logic              wrap_q;

  logic              slot_end;
  logic              frame_wrap;
  logic              in_guard;
  logic [DIGITS-1:0] blank;
  logic [DIGITS-1:0] sel_onehot;
  logic [3:0]        cur_code;
  logic              cur_dp;
  logic              cur_blank;
  logic [6:0]        seg_n;
  logic              dp_n;
  logic [DIGITS-1:0] dig_n;

  function automatic logic [6:0] decode(input logic [3:0] code);
    logic [6:0] s;
    case (code)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      default: s = 7'h71;
    endcase
    if (HEX_EN == 0 && code > 4'd9) s = 7'h00;
    return s;
  endfunction

  assign slot_end   = (slot_cnt == SLOT_LAST);
  assign frame_wrap = slot_end && (idx == IDX_LAST);
  assign in_guard   = int'(slot_cnt) < GUARD;

  // Blank from the most significant digit down while digits are plain zeros.
  always_comb begin
    logic lead;
    blank = '0;
    lead  = lz_suppress;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      if (lead && active[i] == 4'd0 && !active_dp[i]) blank[i] = 1'b1;
      else lead = 1'b0;
    end
  end

  always_comb begin
    cur_code   = '0;
    cur_dp     = 1'b0;
    cur_blank  = 1'b0;
    sel_onehot = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx == IDX_W'(i)) begin
        cur_code      = active[i];
        cur_dp        = active_dp[i];
        cur_blank     = blank[i];
        sel_onehot[i] = 1'b1;
      end
    end
    seg_n = (in_guard || cur_blank) ? 7'h00 : decode(cur_code);
    dp_n  = in_guard ? 1'b0 : cur_dp;
    dig_n = in_guard ? '0 : sel_onehot;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      slot_cnt   <= '0;
      idx        <= '0;
      pending    <= 1'b0;
      wrap_q     <= 1'b0;
      frame_tick <= 1'b0;
      shadow_dp  <= '0;
      active_dp  <= '0;
      for (int i = 0; i < DIGITS; i++) begin
        shadow[i] <= '0;
        active[i] <= '0;
      end
      seg_out <= {7{INV}};
      dp_out  <= INV;
      dig_sel <= {DIGITS{INV}};
    end else begin
      slot_cnt <= slot_end ? '0 : slot_cnt + 1'b1;
      if (slot_end) idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;

      // frame_tick lines up with the first registered output of digit 0.
      wrap_q     <= frame_wrap;
      frame_tick <= wrap_q;

      if (frame_wrap && pending) begin
        for (int i = 0; i < DIGITS; i++) active[i] <= shadow[i];
        active_dp <= shadow_dp;
        pending   <= 1'b0;
      end else if (commit && !pending) begin
        pending <= 1'b1;
      end

      for (int i = 0; i < DIGITS; i++) begin
        if (wr_en && wr_addr == 3'(i)) begin
          shadow[i]    <= wr_data;
          shadow_dp[i] <= wr_dp;
        end
      end

      seg_out <= seg_n ^ {7{INV}};
      dp_out  <= dp_n ^ INV;
      dig_sel <= dig_n ^ {DIGITS{INV}};
    end
  end

endmodule
